mips_mdu: RTL

//  Multiply/divide unit for the 5-stage pipelined MIPS core, sitting beside the ALU in EX.

---
 rtl/mips_mdu_pkg.sv | 30 +++
 rtl/mips_mdu_divider.sv | 51 +++++
 rtl/mips_mdu.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mips_mdu_pkg.sv
// Purpose: shared op encodings, state encoding and default cycle counts for the MIPS MDU.
// Latency: n/a (definitions only).
// Backpressure: n/a. Decoder and hazard logic import the same package so encodings stay aligned.
package mips_mdu_pkg;

  localparam int MDU_W               = 32;
  localparam int MDU_MULT_CYCLES_DEF = 5;
  localparam int MDU_DIV_CYCLES_DEF  = 10;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // Multi-cycle operations: the ones that raise busy and write both HI and LO.
  function automatic logic is_long_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mips_mdu_divider.sv
// Purpose: combinational 32-bit signed/unsigned divider with MIPS divide-by-zero/overflow results.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows the inputs.
// Ports: dividend/divisor (32b) in, is_signed in, quotient/remainder (32b) out.
module mips_mdu_divider
  import mips_mdu_pkg::*;
(
  input  logic [MDU_W-1:0] dividend,
  input  logic [MDU_W-1:0] divisor,
  input  logic             is_signed,
  output logic [MDU_W-1:0] quotient,
  output logic [MDU_W-1:0] remainder
);

  logic             neg_a;
  logic             neg_b;
  logic [MDU_W-1:0] mag_a;
  logic [MDU_W-1:0] mag_b;
  logic [MDU_W-1:0] safe_b;
  logic [MDU_W-1:0] q_mag;
  logic [MDU_W-1:0] r_mag;
  logic             div_zero;
  logic             div_ovf;

  // Signed division is done on magnitudes so the unsigned divider is shared;
  // the quotient is negated when the signs differ, the remainder follows the dividend.
  assign neg_a    = is_signed & dividend[MDU_W-1];
  assign neg_b    = is_signed & divisor[MDU_W-1];
  assign mag_a    = neg_a ? (~dividend + 1'b1) : dividend;
  assign mag_b    = neg_b ? (~divisor + 1'b1) : divisor;
  assign div_zero = (divisor == '0);
  assign div_ovf  = is_signed && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);

  // Keep the behavioural divider away from a zero divisor; that result is overridden below.
  assign safe_b = div_zero ? 32'd1 : mag_b;
  assign q_mag  = mag_a / safe_b;
  assign r_mag  = mag_a % safe_b;

  always_comb begin
    quotient  = (neg_a ^ neg_b) ? (~q_mag + 1'b1) : q_mag;
    remainder = neg_a ? (~r_mag + 1'b1) : r_mag;
    if (div_zero) begin
      quotient  = 32'hFFFF_FFFF;
      remainder = dividend;
    end else if (div_ovf) begin
      quotient  = 32'h8000_0000;
      remainder = '0;
    end
  end

endmodule

// File: rtl/mips_mdu.sv
// Purpose: MIPS multiply/divide unit owning HI/LO; mult/multu/div/divu plus single-cycle mthi/mtlo.
// Latency: busy for MULT_CYCLES / DIV_CYCLES cycles; hi/lo final in the first busy=0 cycle.
// Backpressure: none; start is ignored while busy, the hazard unit must hold issue off.
// Ports: clk, reset (async active-low), start/op(3b)/a(32b)/b(32b) in; busy, hi(32b), lo(32b) out.
module mips_mdu
  import mips_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [MDU_W-1:0] a,
  input  logic [MDU_W-1:0] b,
  output logic             busy,
  output logic [MDU_W-1:0] hi,
  output logic [MDU_W-1:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_e       state;
  mdu_state_e       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_q;
  logic [MDU_W-1:0] a_q;
  logic [MDU_W-1:0] b_q;

  logic             launch;
  logic             done;
  logic             wr_mthi;
  logic             wr_mtlo;

  logic [63:0]      prod_s;
  logic [63:0]      prod_u;
  logic [MDU_W-1:0] div_q;
  logic [MDU_W-1:0] div_r;
  logic [MDU_W-1:0] res_hi;
  logic [MDU_W-1:0] res_lo;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start && is_long_op(op)) state_nxt = ST_RUN;
      ST_RUN:  if (cnt == CNT_W'(1))        state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // start is only honoured in IDLE, so mthi/mtlo issued during RUN are dropped.
  always_comb begin
    busy    = (state == ST_RUN);
    done    = (state == ST_RUN) && (cnt == CNT_W'(1));
    launch  = (state == ST_IDLE) && start && is_long_op(op);
    wr_mthi = (state == ST_IDLE) && start && (op == OP_MTHI);
    wr_mtlo = (state == ST_IDLE) && start && (op == OP_MTLO);
  end

  // ---------------- operand latch and cycle counter ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      op_q <= OP_NOP;
      a_q  <= '0;
      b_q  <= '0;
    end else if (launch) begin
      cnt  <= ((op == OP_MULT) || (op == OP_MULTU)) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
      op_q <= op;
      a_q  <= a;
      b_q  <= b;
    end else if (busy) begin
      cnt  <= cnt - CNT_W'(1);
    end
  end

  // ---------------- result datapath (latched operands only) ----------------
  assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  mips_mdu_divider u_div (
    .dividend  (a_q),
    .divisor   (b_q),
    .is_signed (op_q == OP_DIV),
    .quotient  (div_q),
    .remainder (div_r)
  );

  always_comb begin
    res_hi = hi;
    res_lo = lo;
    case (op_q)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV,
      OP_DIVU:  begin
        res_hi = div_r;
        res_lo = div_q;
      end
      default:  ;
    endcase
  end

  // ---------------- HI/LO registers ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi <= '0;
      lo <= '0;
    end else if (done) begin
      hi <= res_hi;
      lo <= res_lo;
    end else begin
      if (wr_mthi) hi <= a;
      if (wr_mtlo) lo <= a;
    end
  end

endmodule
